// File: rtl/lcd_refresh_sequencer.sv
// HD44780 16x2 driver: power-up wait, init commands, then continuous two-line refresh from a string ROM.
// Optional macro LCD_HEX_CONVERT_EN converts data bytes 0x00..0x0F to ASCII hex digits.
module lcd_refresh_sequencer #(
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 16,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000,
  parameter int PWR_WAIT_CYC   = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] menu_in,
  output logic [4:0] menu_out,
  output logic [4:0] char_index,
  input  logic [7:0] char_in,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       init_done,
  output logic       frame_done
);

  localparam int MAX_A   = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int MAX_C   = (MAX_B > PWR_WAIT_CYC) ? MAX_B : PWR_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_WAIT_CYC - 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, L1_ADDR, WR_CHAR, L2_ADDR} seq_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  seq_t             seq_reg, seq_next;
  phase_t           phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       step_reg, step_next;
  logic [4:0]       index_reg, index_next;
  logic [4:0]       menu_reg, menu_next;
  logic [7:0]       data_reg, data_next;
  logic             rs_reg, rs_next;
  logic             en_reg, en_next;
  logic             on_reg;
  logic             init_done_reg, init_done_next;
  logic             frame_done_reg, frame_done_next;
  logic             start_txn;
  logic [CNT_W-1:0] wait_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] to_char(input logic [7:0] raw);
`ifdef LCD_HEX_CONVERT_EN
    if (raw[7:4] != 4'h0)
      return raw;
    else if (raw[3:0] < 4'hA)
      return 8'h30 + {4'h0, raw[3:0]};
    else
      return 8'h37 + {4'h0, raw[3:0]};
`else
    return raw;
`endif
  endfunction

  // Only a clear command needs the long settle time.
  assign wait_last = (!rs_reg && data_reg == 8'h01) ? CLEAR_LAST : CMD_LAST;

  always_comb begin
    seq_next        = seq_reg;
    phase_next      = phase_reg;
    cnt_next        = cnt_reg + CNT_W'(1);
    step_next       = step_reg;
    index_next      = index_reg;
    menu_next       = menu_reg;
    data_next       = data_reg;
    rs_next         = rs_reg;
    en_next         = 1'b0;
    init_done_next  = init_done_reg;
    frame_done_next = 1'b0;
    start_txn       = 1'b0;

    if (seq_reg == PWR_WAIT) begin
      if (cnt_reg == PWR_LAST) begin
        seq_next  = INIT;
        start_txn = 1'b1;
      end
    end else begin
      case (phase_reg)
        PH_SETUP: begin
          if (cnt_reg == SETUP_LAST) begin
            phase_next = PH_PULSE;
            cnt_next   = '0;
            en_next    = 1'b1;
          end
        end
        PH_PULSE: begin
          en_next = 1'b1;
          if (cnt_reg == PULSE_LAST) begin
            phase_next = PH_WAIT;
            cnt_next   = '0;
            en_next    = 1'b0;
            // Advance early so the ROM output settles during WAIT; 0x1F wraps to 0.
            if (seq_reg == WR_CHAR)
              index_next = index_reg + 5'd1;
          end
        end
        default: begin
          if (cnt_reg == wait_last) begin
            start_txn = 1'b1;
            case (seq_reg)
              INIT: begin
                if (step_reg == 2'd3) begin
                  init_done_next = 1'b1;
                  seq_next       = L1_ADDR;
                end else begin
                  step_next = step_reg + 2'd1;
                end
              end
              L1_ADDR, L2_ADDR: seq_next = WR_CHAR;
              WR_CHAR: begin
                if (index_reg == 5'h10) begin
                  seq_next = L2_ADDR;
                end else if (index_reg == 5'h00) begin
                  seq_next        = L1_ADDR;
                  frame_done_next = 1'b1;
                end
              end
              default: seq_next = seq_reg;
            endcase
          end
        end
      endcase
    end

    if (start_txn) begin
      phase_next = PH_SETUP;
      cnt_next   = '0;
      rs_next    = 1'b0;
      case (seq_next)
        INIT:    data_next = init_cmd(step_next);
        L1_ADDR: begin
          data_next  = 8'h80;
          index_next = 5'h00;
          menu_next  = menu_in;
        end
        L2_ADDR: data_next = 8'hC0;
        default: begin
          data_next = to_char(char_in);
          rs_next   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_reg        <= PWR_WAIT;
      phase_reg      <= PH_SETUP;
      cnt_reg        <= '0;
      step_reg       <= 2'd0;
      index_reg      <= 5'h00;
      menu_reg       <= 5'h00;
      data_reg       <= 8'h00;
      rs_reg         <= 1'b0;
      en_reg         <= 1'b0;
      on_reg         <= 1'b0;
      init_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      seq_reg        <= seq_next;
      phase_reg      <= phase_next;
      cnt_reg        <= cnt_next;
      step_reg       <= step_next;
      index_reg      <= index_next;
      menu_reg       <= menu_next;
      data_reg       <= data_next;
      rs_reg         <= rs_next;
      en_reg         <= en_next;
      on_reg         <= 1'b1;
      init_done_reg  <= init_done_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign menu_out   = menu_reg;
  assign char_index = index_reg;
  assign lcd_data   = data_reg;
  assign lcd_rs     = rs_reg;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_reg;
  assign lcd_on     = on_reg;
  assign init_done  = init_done_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Self-checking bench for lcd_refresh_sequencer: expected bus writes queued per scenario, compared per enable strobe.
module tb_lcd_refresh_sequencer;
  localparam int SETUP_CYC      = 1;
  localparam int E_PULSE_CYC    = 2;
  localparam int CMD_WAIT_CYC   = 3;
  localparam int CLEAR_WAIT_CYC = 8;
  localparam int PWR_WAIT_CYC   = 10;
  localparam int STROBE_LIMIT   = 200;

  logic       clk, rst_n;
  logic [4:0] menu_in, menu_out, char_index;
  logic [7:0] char_in, lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, init_done, frame_done;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic [4:0] menu;
    logic       init_done;
    int         width;
    bit         stable;
    bit         rw_ok;
    bit         timeout;
    int         rise_cyc;
    int         fall_cyc;
  } strobe_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic [4:0] menu;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rel_cyc = 0;
  int   fd_rises = 0;
  int   fd_samples = 0;
  logic fd_prev = 1'b0;
  logic rom_hex = 1'b0;
  logic [7:0] hex_tbl [5] = '{8'h00, 8'h09, 8'h0A, 8'h0F, 8'h2D};

  lcd_refresh_sequencer #(
    .SETUP_CYC(SETUP_CYC), .E_PULSE_CYC(E_PULSE_CYC), .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC), .PWR_WAIT_CYC(PWR_WAIT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .menu_in(menu_in), .menu_out(menu_out),
    .char_index(char_index), .char_in(char_in), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on), .init_done(init_done),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // String ROM model: 0x41+index, or the hex test table on indices 0..4.
  always_comb begin
    char_in = 8'h41 + {3'b000, char_index};
    if (rom_hex && char_index < 5'd5) char_in = hex_tbl[char_index[2:0]];
  end

  task automatic sample_fd();
    if (frame_done === 1'b1) fd_samples++;
    if (frame_done === 1'b1 && fd_prev !== 1'b1) fd_rises++;
    fd_prev = frame_done;
  endtask

  // Capture the next complete enable strobe (no comparisons here).
  task automatic next_strobe(output strobe_t s);
    int n;
    s.data = '0; s.rs = 1'b0; s.menu = '0; s.init_done = 1'b0; s.width = 0;
    s.stable = 1'b1; s.rw_ok = 1'b1; s.timeout = 1'b0; s.rise_cyc = 0; s.fall_cyc = 0;
    n = 0;
    do begin
      @(negedge clk); n++; sample_fd();
      if (lcd_rw !== 1'b0) s.rw_ok = 1'b0;
    end while (lcd_en !== 1'b1 && n < STROBE_LIMIT);
    if (lcd_en !== 1'b1) begin s.timeout = 1'b1; return; end
    s.rise_cyc = cyc; s.data = lcd_data; s.rs = lcd_rs; s.menu = menu_out; s.init_done = init_done;
    while (lcd_en === 1'b1 && n < STROBE_LIMIT) begin
      s.width++;
      if (lcd_data !== s.data || lcd_rs !== s.rs) s.stable = 1'b0;
      if (lcd_rw !== 1'b0) s.rw_ok = 1'b0;
      @(negedge clk); n++; sample_fd();
    end
    if (lcd_en === 1'b1) s.timeout = 1'b1;
    s.fall_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_data, lcd_rs, lcd_rw, lcd_en, char_index, menu_out, init_done, frame_done} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got data=%02h rs=%b rw=%b en=%b idx=%02h menu=%02h init=%b frame=%b required all zero",
               lcd_data, lcd_rs, lcd_rw, lcd_en, char_index, menu_out, init_done, frame_done);
    end
    checks++;
    if (lcd_on !== 1'b0) begin failures++; $display("FAIL reset_lcd_on got %b required 0", lcd_on); end
    rst_n = 1'b1;
    rel_cyc = cyc;
    checks++;
    if (lcd_on !== 1'b0) begin failures++; $display("FAIL lcd_on_before_edge got %b required 0", lcd_on); end
    @(posedge clk); #1;
    checks++;
    if (lcd_on !== 1'b1) begin failures++; $display("FAIL lcd_on_after_release got %b required 1", lcd_on); end
  endtask

  task automatic test_init();
    strobe_t s; exp_t e; int n; int prev_fall;
    sb.push_back('{8'h38, 1'b0, 5'd0});
    sb.push_back('{8'h0C, 1'b0, 5'd0});
    sb.push_back('{8'h01, 1'b0, 5'd0});
    sb.push_back('{8'h06, 1'b0, 5'd0});
    sb.push_back('{8'h80, 1'b0, 5'd0});
    n = 0; prev_fall = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      next_strobe(s);
      checks++;
      if (s.timeout || {s.rs, s.data} !== {e.rs, e.data}) begin
        failures++;
        $display("FAIL init_cmd[%0d] got rs=%b data=%02h timeout=%b required rs=%b data=%02h",
                 n, s.rs, s.data, s.timeout, e.rs, e.data);
      end
      if (n == 0) begin
        checks++;
        if (s.rise_cyc - rel_cyc != PWR_WAIT_CYC + SETUP_CYC) begin
          failures++;
          $display("FAIL first_en_rise got %0d cycles required %0d", s.rise_cyc - rel_cyc, PWR_WAIT_CYC + SETUP_CYC);
        end
      end
      if (n == 1) begin
        checks++;
        if (s.rise_cyc - prev_fall != CMD_WAIT_CYC + SETUP_CYC) begin
          failures++;
          $display("FAIL cmd_gap got %0d required %0d", s.rise_cyc - prev_fall, CMD_WAIT_CYC + SETUP_CYC);
        end
      end
      if (n == 3) begin
        checks++;
        if (s.rise_cyc - prev_fall != CLEAR_WAIT_CYC + SETUP_CYC) begin
          failures++;
          $display("FAIL clear_gap got %0d required %0d", s.rise_cyc - prev_fall, CLEAR_WAIT_CYC + SETUP_CYC);
        end
        checks++;
        if (s.init_done !== 1'b0) begin failures++; $display("FAIL init_done_early got %b required 0", s.init_done); end
      end
      if (n == 4) begin
        checks++;
        if (s.init_done !== 1'b1) begin failures++; $display("FAIL init_done_set got %b required 1", s.init_done); end
      end
      prev_fall = s.fall_cyc;
      n++;
    end
  endtask

  task automatic test_frame();
    strobe_t s; exp_t e; int n;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) sb.push_back('{8'hC0, 1'b0, 5'd0});
      sb.push_back('{8'h41 + 8'(i), 1'b1, 5'd0});
    end
    sb.push_back('{8'h80, 1'b0, 5'd0});
    fd_rises = 0; fd_samples = 0;
    n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      next_strobe(s);
      checks++;
      if (s.timeout || {s.rs, s.data} !== {e.rs, e.data}) begin
        failures++;
        $display("FAIL frame_write[%0d] got rs=%b data=%02h timeout=%b required rs=%b data=%02h",
                 n, s.rs, s.data, s.timeout, e.rs, e.data);
      end
      checks++;
      if (s.width != E_PULSE_CYC || !s.stable || !s.rw_ok) begin
        failures++;
        $display("FAIL frame_timing[%0d] got width=%0d stable=%b rw_ok=%b required width=%0d stable=1 rw_ok=1",
                 n, s.width, s.stable, s.rw_ok, E_PULSE_CYC);
      end
      n++;
    end
    checks++;
    if (fd_rises != 1 || fd_samples != 1) begin
      failures++;
      $display("FAIL frame_done_pulse got rises=%0d high_cycles=%0d required 1 and 1", fd_rises, fd_samples);
    end
  endtask

  task automatic test_menu();
    strobe_t s; exp_t e; int n;
    for (int i = 0; i <= 8; i++) sb.push_back('{8'h41 + 8'(i), 1'b1, 5'd0});
    n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      next_strobe(s);
      checks++;
      if (s.timeout || {s.rs, s.data, s.menu} !== {e.rs, e.data, e.menu}) begin
        failures++;
        $display("FAIL menu_pre[%0d] got rs=%b data=%02h menu=%02h required rs=%b data=%02h menu=%02h",
                 n, s.rs, s.data, s.menu, e.rs, e.data, e.menu);
      end
      n++;
    end
    menu_in = 5'h01;
    for (int i = 9; i < 32; i++) begin
      if (i == 16) sb.push_back('{8'hC0, 1'b0, 5'd0});
      sb.push_back('{8'h41 + 8'(i), 1'b1, 5'd0});
    end
    sb.push_back('{8'h80, 1'b0, 5'd1});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      next_strobe(s);
      checks++;
      if (s.timeout || {s.rs, s.data, s.menu} !== {e.rs, e.data, e.menu}) begin
        failures++;
        $display("FAIL menu_post[%0d] got rs=%b data=%02h menu=%02h required rs=%b data=%02h menu=%02h",
                 n, s.rs, s.data, s.menu, e.rs, e.data, e.menu);
      end
      n++;
    end
  endtask

  task automatic test_hex();
    strobe_t s; exp_t e; int n;
    rom_hex = 1'b1;
`ifdef LCD_HEX_CONVERT_EN
    sb.push_back('{8'h30, 1'b1, 5'd1});
    sb.push_back('{8'h39, 1'b1, 5'd1});
    sb.push_back('{8'h41, 1'b1, 5'd1});
    sb.push_back('{8'h46, 1'b1, 5'd1});
    sb.push_back('{8'h2D, 1'b1, 5'd1});
`else
    sb.push_back('{8'h00, 1'b1, 5'd1});
    sb.push_back('{8'h09, 1'b1, 5'd1});
    sb.push_back('{8'h0A, 1'b1, 5'd1});
    sb.push_back('{8'h0F, 1'b1, 5'd1});
    sb.push_back('{8'h2D, 1'b1, 5'd1});
`endif
    n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      next_strobe(s);
      checks++;
      if (s.timeout || {s.rs, s.data} !== {e.rs, e.data}) begin
        failures++;
        $display("FAIL hex_char[%0d] got rs=%b data=%02h required rs=%b data=%02h", n, s.rs, s.data, e.rs, e.data);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    strobe_t s; exp_t e; int n;
    rom_hex = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (lcd_en !== 1'b1 && n < STROBE_LIMIT);
    checks++;
    if (lcd_en !== 1'b1 || {lcd_rs, lcd_data} !== {1'b1, 8'h46} || char_index !== 5'h05) begin
      failures++;
      $display("FAIL pulse_idx5 got en=%b rs=%b data=%02h idx=%02h required en=1 rs=1 data=46 idx=05",
               lcd_en, lcd_rs, lcd_data, char_index);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (lcd_en !== 1'b0) begin failures++; $display("FAIL async_en_drop got %b required 0", lcd_en); end
    checks++;
    if ({lcd_data, lcd_rs, lcd_rw, lcd_on, char_index, menu_out, init_done, frame_done} !== 23'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got data=%02h rs=%b on=%b idx=%02h menu=%02h init=%b frame=%b required all zero",
               lcd_data, lcd_rs, lcd_on, char_index, menu_out, init_done, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    sb.push_back('{8'h38, 1'b0, 5'd0});
    sb.push_back('{8'h0C, 1'b0, 5'd0});
    sb.push_back('{8'h01, 1'b0, 5'd0});
    sb.push_back('{8'h06, 1'b0, 5'd0});
    sb.push_back('{8'h80, 1'b0, 5'd1});
    sb.push_back('{8'h41, 1'b1, 5'd1});
    n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      next_strobe(s);
      checks++;
      if (s.timeout || {s.rs, s.data, s.menu} !== {e.rs, e.data, e.menu}) begin
        failures++;
        $display("FAIL reinit[%0d] got rs=%b data=%02h menu=%02h required rs=%b data=%02h menu=%02h",
                 n, s.rs, s.data, s.menu, e.rs, e.data, e.menu);
      end
      if (n == 0) begin
        checks++;
        if (s.rise_cyc - rel_cyc != PWR_WAIT_CYC + SETUP_CYC) begin
          failures++;
          $display("FAIL reinit_first_rise got %0d required %0d", s.rise_cyc - rel_cyc, PWR_WAIT_CYC + SETUP_CYC);
        end
      end
      n++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    menu_in = 5'h00;
    test_reset();
    test_init();
    test_frame();
    test_menu();
    test_hex();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
